// File: rtl/net_pkg.sv
// Shared types and sizing helpers for the neural-net control sequencer.
package net_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ACT   = 3'd4,
        ST_WRITE = 3'd5
    } state_t;

    localparam logic LAYER_HID = 1'b0;
    localparam logic LAYER_OUT = 1'b1;

    typedef struct packed {
        int unsigned fanin;
        int unsigned count;
    } layer_cfg_t;

    // Fan-in and neuron count of the selected layer.
    function automatic layer_cfg_t layer_cfg(input logic        layer,
                                             input int unsigned n_in,
                                             input int unsigned n_hid,
                                             input int unsigned n_out);
        layer_cfg_t cfg;
        if (layer == LAYER_HID) begin
            cfg.fanin = n_in;
            cfg.count = n_hid;
        end else begin
            cfg.fanin = n_hid;
            cfg.count = n_out;
        end
        return cfg;
    endfunction

    // Total ROM words: every neuron stores a bias plus one weight per input.
    function automatic int unsigned total_weights(input int unsigned n_in,
                                                  input int unsigned n_hid,
                                                  input int unsigned n_out);
        return n_hid * (n_in + 1) + n_out * (n_hid + 1);
    endfunction

endpackage

// File: rtl/net_sequencer_if.sv
// Control bus between the sequencer (master) and the MAC/ROM datapath (slave).
interface net_sequencer_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned IW = 2
);
    logic          start;
    logic          busy;
    logic          done;
    logic          in_load;
    logic [AW-1:0] w_addr;
    logic          mac_en;
    logic          mac_first;
    logic          src_layer;
    logic [IW-1:0] src_idx;
    logic          act_en;
    logic          wr_en;
    logic          wr_layer;
    logic [IW-1:0] wr_idx;

    modport master (
        input  start,
        output busy, done, in_load, w_addr, mac_en, mac_first, src_layer,
               src_idx, act_en, wr_en, wr_layer, wr_idx
    );

    modport slave (
        output start,
        input  busy, done, in_load, w_addr, mac_en, mac_first, src_layer,
               src_idx, act_en, wr_en, wr_layer, wr_idx
    );
endinterface

// File: rtl/net_start_edge.sv
// Rising-edge detector for the start button; the history resets high so a
// button held through reset must be released before it can start a run.
module net_start_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_rise_c
);
    logic r_start_q;

    always_ff @(posedge clk) begin
        if (rst) r_start_q <= 1'b1;
        else     r_start_q <= i_start;
    end

    assign o_rise_c = i_start & ~r_start_q;
endmodule

// File: rtl/net_sequencer.sv
// Walks every hidden then output neuron through one shared MAC: issues ROM
// addresses, delayed MAC strobes, activation and write-back, then flags done.
module net_sequencer
    import net_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_HID = 2,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned AW    = 4,
    parameter int unsigned IW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    net_sequencer_if.master bus
);
    localparam int unsigned MAX_F   = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int unsigned MAX_N   = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int unsigned MAX_IDX = (MAX_F > N_OUT) ? MAX_F : N_OUT;
    localparam int unsigned KW      = $clog2(MAX_F + 1);
    localparam int unsigned NW      = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    if (AW < $clog2(total_weights(N_IN, N_HID, N_OUT))) begin : g_aw_check
        $error("AW too narrow for the weight ROM");
    end
    if (IW < $clog2(MAX_IDX)) begin : g_iw_check
        $error("IW too narrow for operand/neuron index");
    end

    logic w_start_rise;

    net_start_edge u_start_edge (
        .clk      (clk),
        .rst      (rst),
        .i_start  (bus.start),
        .o_rise_c (w_start_rise)
    );

    state_t        r_state,     w_state_nxt;
    logic          r_layer,     w_layer_nxt;
    logic [NW-1:0] r_neuron,    w_neuron_nxt;
    logic [KW-1:0] r_k,         w_k_nxt;
    logic [AW-1:0] r_w_addr,    w_addr_nxt;
    logic          r_busy,      w_busy_nxt;
    logic          r_done,      w_done_nxt;
    logic          r_in_load,   w_in_load_nxt;
    logic          r_mac_en,    w_mac_en_nxt;
    logic          r_mac_first, w_mac_first_nxt;
    logic          r_src_layer, w_src_layer_nxt;
    logic [IW-1:0] r_src_idx,   w_src_idx_nxt;
    logic          r_act_en,    w_act_en_nxt;
    logic          r_wr_en,     w_wr_en_nxt;
    logic          r_wr_layer,  w_wr_layer_nxt;
    logic [IW-1:0] r_wr_idx,    w_wr_idx_nxt;

    layer_cfg_t    w_cfg;
    logic [KW-1:0] w_fanin;
    logic [NW-1:0] w_last_neuron;

    assign w_cfg         = layer_cfg(r_layer, N_IN, N_HID, N_OUT);
    assign w_fanin       = KW'(w_cfg.fanin);
    assign w_last_neuron = NW'(w_cfg.count - 1);

    // Next-state and next-output logic; every strobe is registered.
    always_comb begin
        w_state_nxt     = r_state;
        w_layer_nxt     = r_layer;
        w_neuron_nxt    = r_neuron;
        w_k_nxt         = r_k;
        w_addr_nxt      = r_w_addr;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_in_load_nxt   = 1'b0;
        w_mac_en_nxt    = 1'b0;
        w_mac_first_nxt = 1'b0;
        w_src_layer_nxt = 1'b0;
        w_src_idx_nxt   = '0;
        w_act_en_nxt    = 1'b0;
        w_wr_en_nxt     = 1'b0;
        w_wr_layer_nxt  = 1'b0;
        w_wr_idx_nxt    = '0;

        // ROM word issued this cycle is consumed by the MAC next cycle.
        if (r_state == ST_ISSUE) begin
            w_mac_en_nxt    = 1'b1;
            w_mac_first_nxt = (r_k == '0);
            w_src_layer_nxt = r_layer;
            w_src_idx_nxt   = (r_k == '0) ? '0 : IW'(r_k - KW'(1));
        end

        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt   = ST_LOAD;
                    w_done_nxt    = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_in_load_nxt = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt  = ST_ISSUE;
                w_layer_nxt  = LAYER_HID;
                w_neuron_nxt = '0;
                w_k_nxt      = '0;
                w_addr_nxt   = '0;
            end
            ST_ISSUE: begin
                if (r_k == w_fanin) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_k_nxt    = r_k + KW'(1);
                    w_addr_nxt = r_w_addr + AW'(1);
                end
            end
            ST_DRAIN: begin
                w_state_nxt  = ST_ACT;
                w_act_en_nxt = 1'b1;
            end
            ST_ACT: begin
                w_state_nxt    = ST_WRITE;
                w_wr_en_nxt    = 1'b1;
                w_wr_layer_nxt = r_layer;
                w_wr_idx_nxt   = IW'(r_neuron);
            end
            ST_WRITE: begin
                if (r_neuron == w_last_neuron && r_layer == LAYER_OUT) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_ISSUE;
                    w_k_nxt     = '0;
                    w_addr_nxt  = r_w_addr + AW'(1);
                    if (r_neuron == w_last_neuron) begin
                        w_layer_nxt  = LAYER_OUT;
                        w_neuron_nxt = '0;
                    end else begin
                        w_neuron_nxt = r_neuron + NW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_layer     <= LAYER_HID;
            r_neuron    <= '0;
            r_k         <= '0;
            r_w_addr    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_load   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_mac_first <= 1'b0;
            r_src_layer <= 1'b0;
            r_src_idx   <= '0;
            r_act_en    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_layer  <= 1'b0;
            r_wr_idx    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_layer     <= w_layer_nxt;
            r_neuron    <= w_neuron_nxt;
            r_k         <= w_k_nxt;
            r_w_addr    <= w_addr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_in_load   <= w_in_load_nxt;
            r_mac_en    <= w_mac_en_nxt;
            r_mac_first <= w_mac_first_nxt;
            r_src_layer <= w_src_layer_nxt;
            r_src_idx   <= w_src_idx_nxt;
            r_act_en    <= w_act_en_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_layer  <= w_wr_layer_nxt;
            r_wr_idx    <= w_wr_idx_nxt;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.in_load   = r_in_load;
    assign bus.w_addr    = r_w_addr;
    assign bus.mac_en    = r_mac_en;
    assign bus.mac_first = r_mac_first;
    assign bus.src_layer = r_src_layer;
    assign bus.src_idx   = r_src_idx;
    assign bus.act_en    = r_act_en;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_layer  = r_wr_layer;
    assign bus.wr_idx    = r_wr_idx;
endmodule

// File: tb/tb_net_sequencer.sv
// Directed bench: per-cycle output table for the default 2-2-2 net, plus
// corner sequences and a strobe-count run on a 2-3-2 instance.
module tb_net_sequencer;

    typedef struct packed {
        logic       in_load;
        logic [3:0] w_addr;
        logic       mac_en;
        logic       mac_first;
        logic       src_layer;
        logic [1:0] src_idx;
        logic       act_en;
        logic       wr_en;
        logic       wr_layer;
        logic [1:0] wr_idx;
        logic       busy;
        logic       done;
    } outs_t;

    logic clk;
    logic rst;

    net_sequencer_if #(.AW(4), .IW(2)) bus1 ();
    net_sequencer_if #(.AW(5), .IW(2)) bus2 ();

    net_sequencer #(.N_IN(2), .N_HID(2), .N_OUT(2), .AW(4), .IW(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    net_sequencer #(.N_IN(2), .N_HID(3), .N_OUT(2), .AW(5), .IW(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outs_t act1;
    assign act1 = {bus1.in_load, bus1.w_addr, bus1.mac_en, bus1.mac_first,
                   bus1.src_layer, bus1.src_idx, bus1.act_en, bus1.wr_en,
                   bus1.wr_layer, bus1.wr_idx, bus1.busy, bus1.done};

    int n_tests = 0;
    int n_fail  = 0;
    int n_mac1 = 0, n_first1 = 0, n_act1 = 0, n_wr1 = 0;
    int n_mac2 = 0, n_first2 = 0, n_act2 = 0, n_wr2 = 0;

    // Strobe counters: each counts the cycle that ends at this edge.
    always @(posedge clk) begin
        if (bus1.mac_en)    n_mac1   <= n_mac1 + 1;
        if (bus1.mac_first) n_first1 <= n_first1 + 1;
        if (bus1.act_en)    n_act1   <= n_act1 + 1;
        if (bus1.wr_en)     n_wr1    <= n_wr1 + 1;
        if (bus2.mac_en)    n_mac2   <= n_mac2 + 1;
        if (bus2.mac_first) n_first2 <= n_first2 + 1;
        if (bus2.act_en)    n_act2   <= n_act2 + 1;
        if (bus2.wr_en)     n_wr2    <= n_wr2 + 1;
    end

    outs_t tbl [0:25];

    function automatic outs_t mk(input int il, input int a, input int me, input int mf,
                                 input int sl, input int si, input int ae, input int we,
                                 input int wl, input int wi, input int b, input int d);
        outs_t o;
        o.in_load   = 1'(il);
        o.w_addr    = 4'(a);
        o.mac_en    = 1'(me);
        o.mac_first = 1'(mf);
        o.src_layer = 1'(sl);
        o.src_idx   = 2'(si);
        o.act_en    = 1'(ae);
        o.wr_en     = 1'(we);
        o.wr_layer  = 1'(wl);
        o.wr_idx    = 2'(wi);
        o.busy      = 1'(b);
        o.done      = 1'(d);
        return o;
    endfunction

    task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic outs_t exp_row(input int c, input logic [3:0] prev);
        outs_t o;
        o = tbl[c];
        if (c == 0) o.w_addr = prev;
        return o;
    endfunction

    // Press start and check every cycle E..E+25; optional release and extra pulses.
    task automatic run_table(input string nm, input int rel_c, input logic [3:0] prev,
                             input int p1, input int p2);
        int m0, f0, a0, w0;
        m0 = n_mac1; f0 = n_first1; a0 = n_act1; w0 = n_wr1;
        bus1.start = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            check_eq($sformatf("%s_c%0d", nm, c), 32'(act1), 32'(exp_row(c, prev)));
            if (c == rel_c) bus1.start = 1'b0;
            if (c == p1 - 1 || c == p2 - 1) bus1.start = 1'b1;
            if (c == p1 || c == p2) bus1.start = 1'b0;
        end
        check_eq({nm, "_nmac"},   32'(n_mac1 - m0),   32'd12);
        check_eq({nm, "_nfirst"}, 32'(n_first1 - f0), 32'd4);
        check_eq({nm, "_nact"},   32'(n_act1 - a0),   32'd4);
        check_eq({nm, "_nwr"},    32'(n_wr1 - w0),    32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   m0, f0, a0, w0, found;

        //            il a  me mf sl si ae we wl wi b  d
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(0, 2, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[6]  = mk(0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[7]  = mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[10] = mk(0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        tbl[11] = mk(0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 5, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        tbl[13] = mk(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[14] = mk(0, 7, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[15] = mk(0, 8, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[16] = mk(0, 8, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[17] = mk(0, 8, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[18] = mk(0, 8, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        tbl[19] = mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[20] = mk(0, 10, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[21] = mk(0, 11, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[22] = mk(0, 11, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[23] = mk(0, 11, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[24] = mk(0, 11, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        tbl[25] = mk(0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset with start toggling, then released while start is still high.
        rst = 1'b1;
        bus1.start = 1'b1;
        bus2.start = 1'b0;
        @(negedge clk);
        check_eq("rst_cyc1", 32'(act1), 32'd0);
        bus1.start = 1'b0;
        @(negedge clk);
        check_eq("rst_cyc2", 32'(act1), 32'd0);
        rst = 1'b0;
        bus1.start = 1'b1;
        @(negedge clk);
        check_eq("rst_held_start", 32'(act1), 32'd0);
        bus1.start = 1'b0;
        ok = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (act1 !== '0) ok = 1'b0;
        end
        check_eq("rst_no_run", 32'(ok), 32'd1);

        run_table("nominal", 4, 4'd0, -1, -1);

        repeat (2) @(negedge clk);
        run_table("midrun_pulses", 2, 4'd11, 8, 15);

        // Start held through completion must not retrigger.
        repeat (2) @(negedge clk);
        run_table("held", -1, 4'd11, -1, -1);
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus1.busy !== 1'b0 || bus1.done !== 1'b1 || bus1.in_load !== 1'b0) ok = 1'b0;
        end
        check_eq("held_single_run", 32'(ok), 32'd1);
        bus1.start = 1'b0;
        repeat (2) @(negedge clk);
        run_table("held_again", 3, 4'd11, -1, -1);

        // Edge arriving during the final WRITE is ignored.
        repeat (2) @(negedge clk);
        run_table("edge_at_write", 2, 4'd11, 25, -1);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus1.busy !== 1'b0 || bus1.in_load !== 1'b0 || bus1.done !== 1'b1) ok = 1'b0;
        end
        check_eq("edge_at_write_idle", 32'(ok), 32'd1);

        // Reset at E+10 with start held: abort, stay idle until re-pressed.
        repeat (2) @(negedge clk);
        bus1.start = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            check_eq($sformatf("prerst_c%0d", c), 32'(act1), 32'(exp_row(c, 4'd11)));
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_outputs", 32'(act1), 32'd0);
        rst = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (act1 !== '0) ok = 1'b0;
        end
        check_eq("rst_mid_stays_idle", 32'(ok), 32'd1);
        bus1.start = 1'b0;
        repeat (2) @(negedge clk);
        run_table("after_rst", 2, 4'd0, -1, -1);

        // Three hidden neurons: 17 MACs, 5 writes, done after E+33.
        m0 = n_mac2; f0 = n_first2; a0 = n_act2; w0 = n_wr2;
        found = -1;
        bus2.start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 2) bus2.start = 1'b0;
            if (bus2.done === 1'b1) begin
                found = c;
                break;
            end
        end
        check_eq("p3_done_cycle", 32'(found), 32'd33);
        check_eq("p3_busy_low",   32'(bus2.busy), 32'd0);
        check_eq("p3_last_addr",  32'(bus2.w_addr), 32'd16);
        check_eq("p3_nmac",   32'(n_mac2 - m0),   32'd17);
        check_eq("p3_nfirst", 32'(n_first2 - f0), 32'd5);
        check_eq("p3_nact",   32'(n_act2 - a0),   32'd5);
        check_eq("p3_nwr",    32'(n_wr2 - w0),    32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
